// File: rtl/sd_sram_block_writer_if.sv
// Bundles the two handshakes of the SD-to-SRAM block writer.
//   in_data / in_valid / in_ready : 32-bit word stream from the SD data-out select stage
//   sram_wdata / sram_addr / sram_wen / sram_ack : SRAM write port
// The writer uses the master modport: it is the sink of the word stream and
// the requester on the SRAM port. The surrounding logic (or a testbench)
// uses the slave modport.
interface sd_sram_block_writer_if #(
  parameter int ADDR_W = 16
);
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       sram_wdata;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_wen;
  logic              sram_ack;

  modport master (
    input  in_data, in_valid, sram_ack,
    output in_ready, sram_wdata, sram_addr, sram_wen
  );

  modport slave (
    output in_data, in_valid, sram_ack,
    input  in_ready, sram_wdata, sram_addr, sram_wen
  );
endinterface

// File: rtl/sd_sram_block_writer.sv
// SD SRAM block writer.
// Accepts the selected 32-bit SD word stream into a small FIFO and writes one
// block of BLOCK_WORDS words to consecutive SRAM addresses, starting at a base
// address latched on start. block_done pulses for one cycle once the last word
// of the block has been accepted by the SRAM.
// Ports:
//   clk, n_rst  : clock (rising edge) and asynchronous active-low reset
//   start       : begin a block (IDLE only); base_addr is latched at the same time
//   abort       : synchronous abort; flushes the FIFO and returns to IDLE
//   bus         : word-stream and SRAM-write handshakes (master modport)
//   busy        : block in progress (state != IDLE)
//   block_done  : one-cycle completion pulse
module sd_sram_block_writer #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 16,
  parameter int BLOCK_WORDS = 128
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  sd_sram_block_writer_if.master bus,
  output logic                  busy,
  output logic                  block_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic [CNT_W-1:0]   accepted, written;
  logic [ADDR_W-1:0]  addr;

  logic in_ready_c, wen_c;
  logic full, empty, start_ok, push, pop, last_pop;

  assign full     = (occ == OCC_W'(DEPTH));
  assign empty    = (occ == '0);
  assign start_ok = (state == IDLE) && start && !abort;
  assign push     = bus.in_valid && in_ready_c;
  assign pop      = wen_c && bus.sram_ack;
  // Leave ACTIVE on the edge that commits the last word, so DONE is the cycle
  // right after the final ack.
  assign last_pop = pop && (written == CNT_W'(BLOCK_WORDS - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; abort wins over every other transition.
  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start_ok) next_state = ACTIVE;
      ACTIVE:  if (abort) next_state = IDLE;
               else if (last_pop) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic, purely from registers (plus nothing from the inputs), so
  // the SRAM request holds steady until acknowledged.
  always_comb begin
    in_ready_c = (state == ACTIVE) && !full && (accepted < CNT_W'(BLOCK_WORDS));
    wen_c      = (state == ACTIVE) && !empty;
    busy       = (state != IDLE);
    block_done = (state == DONE);
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.sram_wen   = wen_c;
  assign bus.sram_addr  = addr;
  // Gate the head so stale or uninitialised storage never shows on the bus.
  assign bus.sram_wdata = wen_c ? mem[rd_ptr] : '0;

  // FIFO storage.
  // NOTE: the data array has no reset; validity is carried by the pointers and
  // occupancy, which are reset, so the storage can map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push && !abort) mem[wr_ptr] <= bus.in_data;
  end

  // Pointers, occupancy, block counters and write address.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      accepted <= '0;
      written  <= '0;
      addr     <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (start_ok) begin
        addr     <= base_addr;
        accepted <= '0;
        written  <= '0;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        accepted <= accepted + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        addr    <= addr + ADDR_W'(1);
        written <= written + CNT_W'(1);
      end
      if (push && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !push) occ <= occ - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_sd_sram_block_writer.sv
// Testbench for sd_sram_block_writer: randomized word stream and SRAM acks,
// compared every cycle against a queue-based reference of the block transfer.
module tb_sd_sram_block_writer;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;
  localparam int BW     = 128;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              block_done;

  sd_sram_block_writer_if #(.ADDR_W(ADDR_W)) bus ();

  sd_sram_block_writer #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .BLOCK_WORDS(BW)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .block_done(block_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_pct;
  int valid_pct;
  int done_cnt;

  // Reference: words accepted but not yet written, plus block progress.
  logic [31:0]       q [$];
  bit                m_active;
  bit                m_done;
  int                m_written;
  int                m_accepted;
  logic [ADDR_W-1:0] m_base;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs at the falling edge, advance the
  // reference over the rising edge, then drive new upstream/ack values.
  task automatic tick();
    bit exp_ready, exp_wen, pop, push;
    @(negedge clk);
    exp_ready = m_active && (q.size() < DEPTH) && (m_accepted < BW);
    exp_wen   = m_active && (q.size() > 0);
    check("in_ready", bus.in_ready, exp_ready);
    check("sram_wen", bus.sram_wen, exp_wen);
    check("busy", busy, m_active || m_done);
    check("block_done", block_done, m_done);
    if (block_done) done_cnt++;
    if (exp_wen) begin
      check("sram_wdata", bus.sram_wdata, q[0]);
      check("sram_addr", bus.sram_addr, ADDR_W'(m_base + ADDR_W'(m_written)));
    end
    push = 1'b0;
    if (abort) begin
      q.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
    end else begin
      pop  = exp_wen && bus.sram_ack;
      push = exp_ready && bus.in_valid;
      if (m_done) m_done = 1'b0;
      else if (!m_active && start) begin
        m_active   = 1'b1;
        m_base     = base_addr;
        m_written  = 0;
        m_accepted = 0;
      end
      if (pop) begin
        void'(q.pop_front());
        m_written++;
      end
      if (push) begin
        q.push_back(bus.in_data);
        m_accepted++;
      end
      if (pop && m_written == BW) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.sram_ack = ($urandom_range(99) < ack_pct);
    // Upstream holds a presented word until it is taken.
    if (push || !bus.in_valid) begin
      bus.in_valid = ($urandom_range(99) < valid_pct);
      bus.in_data  = $urandom;
    end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base);
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((m_active || m_done) && n < budget) begin
      tick();
      n++;
    end
    check("block_timeout", {63'd0, (m_active || m_done)}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst         = 1'b0;
    start         = 1'b0;
    abort         = 1'b0;
    base_addr     = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.sram_ack  = 1'b0;
    ack_pct       = 100;
    valid_pct     = 100;
    m_active      = 1'b0;
    m_done        = 1'b0;
    m_written     = 0;
    m_accepted    = 0;
    m_base        = '0;
    done_cnt      = 0;

    // Reset state.
    #12;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_sram_wen", bus.sram_wen, 0);
    check("rst_sram_wdata", bus.sram_wdata, 0);
    check("rst_sram_addr", bus.sram_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_block_done", block_done, 0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    bus.sram_ack = 1'b1;
    tick();

    // 1: full-rate block from 0x0100 with ack tied high.
    done_cnt = 0;
    pulse_start(16'h0100);
    run_until_idle(400);
    check("t1_done_pulses", done_cnt, 1);
    tick();

    // 2: SRAM stalls for 10 cycles mid-block; FIFO fills and backpressures.
    pulse_start(ADDR_W'($urandom));
    repeat (30) tick();
    ack_pct = 0;
    bus.sram_ack = 1'b0;
    repeat (10) tick();
    check("t2_stall_in_ready", bus.in_ready, 0);
    check("t2_stall_wen", bus.sram_wen, 1);
    ack_pct   = 70;
    valid_pct = 80;
    run_until_idle(2000);

    // 3: address wrap at the top of the SRAM.
    ack_pct   = 60;
    valid_pct = 70;
    pulse_start(16'hFFFE);
    run_until_idle(2000);

    // 4: abort after 50 words, then a fresh block from 0x0200.
    ack_pct   = 80;
    valid_pct = 90;
    done_cnt  = 0;
    pulse_start(ADDR_W'($urandom));
    for (int i = 0; i < 1000 && m_written < 50; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_busy", busy, 0);
    check("t4_abort_wen", bus.sram_wen, 0);
    repeat (5) tick();
    check("t4_no_done", done_cnt, 0);
    pulse_start(16'h0200);
    run_until_idle(2000);
    check("t4_restart_done", done_cnt, 1);

    // 5: asynchronous reset with three words buffered.
    ack_pct   = 0;
    valid_pct = 100;
    bus.sram_ack = 1'b0;
    pulse_start(ADDR_W'($urandom));
    for (int i = 0; i < 20 && q.size() < 3; i++) tick();
    n_rst = 1'b0;
    #1;
    check("t5_rst_in_ready", bus.in_ready, 0);
    check("t5_rst_wen", bus.sram_wen, 0);
    check("t5_rst_wdata", bus.sram_wdata, 0);
    check("t5_rst_addr", bus.sram_addr, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", block_done, 0);
    q.delete();
    m_active = 1'b0;
    m_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_rst   = 1'b1;
    ack_pct = 85;
    bus.sram_ack = 1'b1;
    pulse_start(ADDR_W'($urandom));
    run_until_idle(2000);

    // 6: a second start during ACTIVE must not move the base.
    ack_pct   = 90;
    valid_pct = 90;
    pulse_start(16'h0300);
    repeat (20) tick();
    pulse_start(16'h0AAA);
    run_until_idle(2000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
